slot_alloc: RTL and testbench

- Free-slot allocator that uses a find-first-set on a registered free bitmap to pick the next slot index.
- Sits directly downstream of the leading/trailing-zero counter function; its find-first logic is that counter.
- Offers one slot per cycle over a valid/ready port and takes slot releases over a free port.
- Used by tag/ID pools, e.g. outstanding-transaction IDs and buffer-entry pointers.

---
 rtl/slot_alloc.sv | 90 +++++++++
 tb/tb_slot_alloc.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_alloc.sv
// Free-slot allocator: find-first-set over a registered free bitmap, one offer per cycle, 1-cycle offer latency.
// The offer is held stable while not accepted; illegal releases are dropped and flagged with a one-cycle pulse.
module slot_alloc #(
    parameter int NUM_SLOTS = 8,
    parameter int MODE      = 0,
    localparam int IDX_W    = $clog2(NUM_SLOTS),
    localparam int CNT_W    = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             alloc_valid_o,
    output logic [IDX_W-1:0] alloc_idx_o,
    input  logic             alloc_ready_i,
    input  logic             free_valid_i,
    input  logic [IDX_W-1:0] free_idx_i,
    output logic [CNT_W-1:0] free_cnt_o,
    output logic             double_free_o
);

    localparam logic [IDX_W:0]         SLOT_LIMIT = (IDX_W + 1)'(NUM_SLOTS);
    localparam logic [NUM_SLOTS-1:0]   ONE_HOT0   = {{(NUM_SLOTS - 1){1'b0}}, 1'b1};

    logic [NUM_SLOTS-1:0] free_map;
    logic [NUM_SLOTS-1:0] free_map_nxt;
    logic [NUM_SLOTS-1:0] cand_mask;
    logic [NUM_SLOTS-1:0] rel_mask;
    logic                 cand_found;
    logic [IDX_W-1:0]     cand_idx;
    logic                 load;
    logic                 take;
    logic                 idx_in_range;
    logic                 slot_taken;
    logic                 offer_hit;
    logic                 rel_ok;

    // Last match in the scan wins, so the scan direction sets the priority.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        if (MODE == 0) begin
            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                if (free_map[i]) begin
                    cand_found = 1'b1;
                    cand_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (free_map[i]) begin
                    cand_found = 1'b1;
                    cand_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        load         = ~alloc_valid_o | alloc_ready_i;
        take         = load & cand_found;
        idx_in_range = ({1'b0, free_idx_i} < SLOT_LIMIT);
        rel_mask     = idx_in_range ? (ONE_HOT0 << free_idx_i) : '0;
        cand_mask    = take ? (ONE_HOT0 << cand_idx) : '0;
        slot_taken   = ((free_map & rel_mask) == '0);
        // The offered slot is already cleared in the map but is not the releaser's to return.
        offer_hit    = alloc_valid_o & (alloc_idx_o == free_idx_i);
        rel_ok       = free_valid_i & idx_in_range & slot_taken & ~offer_hit;
        free_map_nxt = (free_map & ~cand_mask) | (rel_ok ? rel_mask : '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_map      <= '1;
            alloc_valid_o <= 1'b0;
            alloc_idx_o   <= '0;
            free_cnt_o    <= CNT_W'(NUM_SLOTS);
            double_free_o <= 1'b0;
        end else begin
            free_map      <= free_map_nxt;
            if (load) begin
                alloc_valid_o <= cand_found;
                if (cand_found) begin
                    alloc_idx_o <= cand_idx;
                end
            end
            free_cnt_o    <= free_cnt_o + CNT_W'(rel_ok) - CNT_W'(take);
            double_free_o <= free_valid_i & ~rel_ok;
        end
    end

endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc: directed scenarios plus randomized traffic against a set-based reference model.
module tb_slot_alloc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     [2];
    logic       rdy     [2];
    logic       fv      [2];
    logic [2:0] fidx    [2];
    logic       o_valid [2];
    logic [2:0] o_idx   [2];
    logic [3:0] o_cnt   [2];
    logic       o_dbl   [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: instance 0 is lowest-first, instance 1 highest-first.
    bit       m_free  [2][8];
    bit       m_valid [2];
    bit [2:0] m_idx   [2];
    bit       m_dbl   [2];

    slot_alloc #(.NUM_SLOTS(8), .MODE(0)) dut0 (
        .clk_i(clk), .rst_i(rst[0]),
        .alloc_valid_o(o_valid[0]), .alloc_idx_o(o_idx[0]), .alloc_ready_i(rdy[0]),
        .free_valid_i(fv[0]), .free_idx_i(fidx[0]),
        .free_cnt_o(o_cnt[0]), .double_free_o(o_dbl[0])
    );

    slot_alloc #(.NUM_SLOTS(8), .MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]),
        .alloc_valid_o(o_valid[1]), .alloc_idx_o(o_idx[1]), .alloc_ready_i(rdy[1]),
        .free_valid_i(fv[1]), .free_idx_i(fidx[1]),
        .free_cnt_o(o_cnt[1]), .double_free_o(o_dbl[1])
    );

    function automatic int pick(int k);
        int c;
        c = -1;
        for (int n = 0; n < 8; n++) begin
            int j;
            j = (k == 0) ? n : 7 - n;
            if (c < 0 && m_free[k][j]) c = j;
        end
        return c;
    endfunction

    function automatic int mcount(int k);
        int s;
        s = 0;
        for (int j = 0; j < 8; j++) s += int'(m_free[k][j]);
        return s;
    endfunction

    // Advance model and DUTs by one clock, using the inputs currently driven.
    task automatic tick();
        bit       nf [2][8];
        bit       nv [2];
        bit [2:0] ni [2];
        bit       nd [2];
        for (int k = 0; k < 2; k++) begin
            bit legal;
            int c;
            for (int j = 0; j < 8; j++) nf[k][j] = m_free[k][j];
            nv[k] = m_valid[k];
            ni[k] = m_idx[k];
            nd[k] = 1'b0;
            if (rst[k]) begin
                for (int j = 0; j < 8; j++) nf[k][j] = 1'b1;
                nv[k] = 1'b0;
                ni[k] = 3'd0;
            end else begin
                legal = fv[k] && !m_free[k][fidx[k]] && !(m_valid[k] && m_idx[k] == fidx[k]);
                nd[k] = fv[k] && !legal;
                if (legal) nf[k][fidx[k]] = 1'b1;
                if (!m_valid[k] || rdy[k]) begin
                    c = pick(k);
                    if (c >= 0) begin
                        nf[k][c] = 1'b0;
                        nv[k]    = 1'b1;
                        ni[k]    = 3'(c);
                    end else begin
                        nv[k] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) m_free[k][j] = nf[k][j];
            m_valid[k] = nv[k];
            m_idx[k]   = ni[k];
            m_dbl[k]   = nd[k];
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1; rst[1] = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_valid[k] !== 1'b0 || o_idx[k] !== 3'd0 || o_cnt[k] !== 4'd8 || o_dbl[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset inst=%0d got v=%0b i=%0d c=%0d d=%0b exp v=0 i=0 c=8 d=0",
                         k, o_valid[k], o_idx[k], o_cnt[k], o_dbl[k]);
            end
        end
    endtask

    task automatic test_hold_offer();
        rst[0] = 1'b0; rdy[0] = 1'b0; fv[0] = 1'b0;
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_idx[0] !== 3'd0 || o_cnt[0] !== 4'd7) begin
            failures++;
            $display("FAIL first_offer got v=%0b i=%0d c=%0d exp v=1 i=0 c=7", o_valid[0], o_idx[0], o_cnt[0]);
        end
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (o_valid[0] !== 1'b1 || o_idx[0] !== 3'd0 || o_cnt[0] !== 4'd7) begin
                failures++;
                $display("FAIL offer_hold cyc=%0d got v=%0b i=%0d c=%0d exp v=1 i=0 c=7",
                         n, o_valid[0], o_idx[0], o_cnt[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0; rdy[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (o_valid[0] !== 1'b1 || o_idx[0] !== 3'(i) || o_cnt[0] !== 4'(7 - i)) begin
                failures++;
                $display("FAIL b2b step=%0d got v=%0b i=%0d c=%0d exp v=1 i=%0d c=%0d",
                         i, o_valid[0], o_idx[0], o_cnt[0], i, 7 - i);
            end
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b0 || o_cnt[0] !== 4'd0) begin
            failures++;
            $display("FAIL b2b_empty got v=%0b c=%0d exp v=0 c=0", o_valid[0], o_cnt[0]);
        end
    endtask

    task automatic test_free_realloc();
        rdy[0] = 1'b0; fv[0] = 1'b1; fidx[0] = 3'd5;
        tick();
        fv[0] = 1'b0;
        checks++;
        if (o_valid[0] !== 1'b0 || o_cnt[0] !== 4'd1) begin
            failures++;
            $display("FAIL free_count got v=%0b c=%0d exp v=0 c=1", o_valid[0], o_cnt[0]);
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_idx[0] !== 3'd5 || o_cnt[0] !== 4'd0) begin
            failures++;
            $display("FAIL realloc got v=%0b i=%0d c=%0d exp v=1 i=5 c=0", o_valid[0], o_idx[0], o_cnt[0]);
        end
    endtask

    task automatic test_double_free();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0; rdy[0] = 1'b0;
        tick();
        fv[0] = 1'b1; fidx[0] = 3'd3;
        tick();
        fv[0] = 1'b0;
        checks++;
        if (o_dbl[0] !== 1'b1 || o_cnt[0] !== 4'd7) begin
            failures++;
            $display("FAIL dbl_free_free got d=%0b c=%0d exp d=1 c=7", o_dbl[0], o_cnt[0]);
        end
        tick();
        checks++;
        if (o_dbl[0] !== 1'b0 || o_cnt[0] !== 4'd7) begin
            failures++;
            $display("FAIL dbl_pulse_len got d=%0b c=%0d exp d=0 c=7", o_dbl[0], o_cnt[0]);
        end
        fv[0] = 1'b1; fidx[0] = 3'd0;
        tick();
        fv[0] = 1'b0;
        checks++;
        if (o_dbl[0] !== 1'b1 || o_valid[0] !== 1'b1 || o_idx[0] !== 3'd0 || o_cnt[0] !== 4'd7) begin
            failures++;
            $display("FAIL dbl_free_offer got d=%0b v=%0b i=%0d c=%0d exp d=1 v=1 i=0 c=7",
                     o_dbl[0], o_valid[0], o_idx[0], o_cnt[0]);
        end
        tick();
        checks++;
        if (o_dbl[0] !== 1'b0) begin
            failures++;
            $display("FAIL dbl_offer_len got d=%0b exp d=0", o_dbl[0]);
        end
    endtask

    task automatic test_simultaneous();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0; rdy[0] = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        rdy[0] = 1'b0; fv[0] = 1'b1; fidx[0] = 3'd4;
        tick();
        fv[0] = 1'b0; rdy[0] = 1'b1;
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_idx[0] !== 3'd4 || o_cnt[0] !== 4'd2) begin
            failures++;
            $display("FAIL simul_setup got v=%0b i=%0d c=%0d exp v=1 i=4 c=2", o_valid[0], o_idx[0], o_cnt[0]);
        end
        fv[0] = 1'b1; fidx[0] = 3'd2;
        tick();
        fv[0] = 1'b0;
        checks++;
        if (o_valid[0] !== 1'b1 || o_idx[0] !== 3'd6 || o_cnt[0] !== 4'd2 || o_dbl[0] !== 1'b0) begin
            failures++;
            $display("FAIL simul_both got v=%0b i=%0d c=%0d d=%0b exp v=1 i=6 c=2 d=0",
                     o_valid[0], o_idx[0], o_cnt[0], o_dbl[0]);
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_idx[0] !== 3'd2 || o_cnt[0] !== 4'd1) begin
            failures++;
            $display("FAIL simul_next got v=%0b i=%0d c=%0d exp v=1 i=2 c=1", o_valid[0], o_idx[0], o_cnt[0]);
        end
        rdy[0] = 1'b0;
    endtask

    task automatic test_mode_high();
        rst[1] = 1'b0; rdy[1] = 1'b0; fv[1] = 1'b0;
        tick();
        checks++;
        if (o_valid[1] !== 1'b1 || o_idx[1] !== 3'd7 || o_cnt[1] !== 4'd7) begin
            failures++;
            $display("FAIL mode1_first got v=%0b i=%0d c=%0d exp v=1 i=7 c=7", o_valid[1], o_idx[1], o_cnt[1]);
        end
        rdy[1] = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        rdy[1] = 1'b0; rst[1] = 1'b1;
        tick();
        checks++;
        if (o_valid[1] !== 1'b0 || o_cnt[1] !== 4'd8 || o_dbl[1] !== 1'b0) begin
            failures++;
            $display("FAIL mode1_reset got v=%0b c=%0d d=%0b exp v=0 c=8 d=0", o_valid[1], o_cnt[1], o_dbl[1]);
        end
        rst[1] = 1'b0;
        tick();
        checks++;
        if (o_valid[1] !== 1'b1 || o_idx[1] !== 3'd7 || o_cnt[1] !== 4'd7) begin
            failures++;
            $display("FAIL mode1_again got v=%0b i=%0d c=%0d exp v=1 i=7 c=7", o_valid[1], o_idx[1], o_cnt[1]);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k]  = ($urandom_range(0, 199) == 0);
                rdy[k]  = 1'($urandom_range(0, 1));
                fv[k]   = ($urandom_range(0, 9) < 4);
                fidx[k] = 3'($urandom_range(0, 7));
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_valid[k] !== m_valid[k] || o_idx[k] !== m_idx[k] ||
                    o_cnt[k] !== 4'(mcount(k)) || o_dbl[k] !== m_dbl[k]) begin
                    failures++;
                    $display("FAIL random inst=%0d cyc=%0d got v=%0b i=%0d c=%0d d=%0b exp v=%0b i=%0d c=%0d d=%0b",
                             k, cyc, o_valid[k], o_idx[k], o_cnt[k], o_dbl[k],
                             m_valid[k], m_idx[k], mcount(k), m_dbl[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; rdy[k] = 1'b0; fv[k] = 1'b0; fidx[k] = 3'd0;
        end
        test_reset();
        test_hold_offer();
        test_back_to_back();
        test_free_realloc();
        test_double_free();
        test_simultaneous();
        test_mode_high();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
